// File: rtl/dr_load_unit.sv
// Load data register: one req/ack read per load with timeout, lane extract and extension.
// Optional DR_BYPASS_EN forwards extended read data to dr_rdata during the ack cycle.
module dr_load_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4,
  localparam int AW     = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [2:0]        ld_mode,
  input  logic [AW-1:0]     ld_addr_lo,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dr_out,
  output logic [DATA_W-1:0] dr_rdata,
  output logic              dr_valid,
  output logic              dr_busy,
  output logic              dr_err
);

  localparam logic [2:0] MODE_W  = 3'b000;
  localparam logic [2:0] MODE_BS = 3'b001;
  localparam logic [2:0] MODE_BU = 3'b010;
  localparam logic [2:0] MODE_HS = 3'b011;
  localparam logic [2:0] MODE_HU = 3'b100;

  if (DATA_W < 32 || (DATA_W % 16) != 0) begin : g_bad_w
    $error("DATA_W must be a multiple of 16 and at least 32");
  end
  if (TIMEOUT < 1 || (2**TO_W) <= TIMEOUT) begin : g_bad_to
    $error("TIMEOUT must be >= 1 and below 2**TO_W");
  end

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t            state;
  logic [2:0]        mode_q;
  logic [AW-1:0]     addr_q;
  logic [TO_W-1:0]   cnt;
  logic [TO_W-1:0]   cnt_nx;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              legal;

  always_comb begin
    legal = 1'b0;
    unique case (ld_mode)
      MODE_W:           legal = (ld_addr_lo == '0);
      MODE_BS, MODE_BU: legal = 1'b1;
      MODE_HS, MODE_HU: legal = ~ld_addr_lo[0];
      default:          legal = 1'b0;
    endcase
  end

  // Move the addressed lane down to bit 0 before extending.
  assign shifted = mem_rdata >> {addr_q, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = shifted[15:0];

  always_comb begin
    ext = mem_rdata;
    unique case (mode_q)
      MODE_BS: ext = {{(DATA_W-8){lane_b[7]}}, lane_b};
      MODE_BU: ext = {{(DATA_W-8){1'b0}}, lane_b};
      MODE_HS: ext = {{(DATA_W-16){lane_h[15]}}, lane_h};
      MODE_HU: ext = {{(DATA_W-16){1'b0}}, lane_h};
      default: ext = mem_rdata;
    endcase
  end

  assign cnt_nx = cnt + TO_W'(1);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= MODE_W;
      addr_q   <= '0;
      cnt      <= '0;
      data_q   <= '0;
      mem_req  <= 1'b0;
      dr_busy  <= 1'b0;
      dr_valid <= 1'b0;
      dr_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_start && legal) begin
            mode_q   <= ld_mode;
            addr_q   <= ld_addr_lo;
            cnt      <= '0;
            dr_valid <= 1'b0;
            dr_err   <= 1'b0;
            mem_req  <= 1'b1;
            dr_busy  <= 1'b1;
            state    <= REQ;
          end else if (ld_start) begin
            dr_valid <= 1'b0;
            dr_err   <= 1'b1;
          end
        end
        REQ: begin
          // Ack takes priority over an expiring timeout.
          if (mem_ack) begin
            data_q   <= ext;
            dr_valid <= 1'b1;
            mem_req  <= 1'b0;
            dr_busy  <= 1'b0;
            state    <= IDLE;
          end else if (cnt_nx == TO_W'(TIMEOUT)) begin
            cnt      <= cnt_nx;
            dr_err   <= 1'b1;
            mem_req  <= 1'b0;
            dr_busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt      <= cnt_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DR_BYPASS_EN
  logic fwd;
  assign fwd      = (state == REQ) && mem_ack;
  assign dr_rdata = dr_out ? (fwd ? ext : data_q) : '0;
`else
  assign dr_rdata = dr_out ? data_q : '0;
`endif

endmodule

// File: tb/tb_dr_load_unit.sv
// Bench for dr_load_unit: directed cases plus random loads against an arithmetic model.
module tb_dr_load_unit;
  localparam int TO = 15;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic [2:0]  ld_mode;
  logic [1:0]  ld_addr_lo;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        dr_out;
  logic [31:0] dr_rdata;
  logic        dr_valid;
  logic        dr_busy;
  logic        dr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_reg;
  logic        exp_valid;
  logic        exp_err;

  dr_load_unit #(.DATA_W(32), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_mode(ld_mode),
    .ld_addr_lo(ld_addr_lo),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .dr_out(dr_out), .dr_rdata(dr_rdata),
    .dr_valid(dr_valid), .dr_busy(dr_busy),
    .dr_err(dr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_ext(
      input int mode, input int addr,
      input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * addr);
    case (mode)
      1: begin
        v = v & 32'hFF;
        if (v >= 128) v = v - 32'd256;
      end
      2: v = v & 32'hFF;
      3: begin
        v = v & 32'hFFFF;
        if (v >= 32768) v = v - 32'd65536;
      end
      4: v = v & 32'hFFFF;
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic bit ref_legal(input int mode,
                                   input int addr);
    if (mode == 0) return addr == 0;
    if (mode == 1 || mode == 2) return 1'b1;
    if (mode == 3 || mode == 4) return (addr % 2) == 0;
    return 1'b0;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_valid"}, 32'(dr_valid), 32'(exp_valid));
    chk({tag, "_err"}, 32'(dr_err), 32'(exp_err));
    chk({tag, "_data"}, dr_rdata, exp_reg);
  endtask

  // ack_at: 0 = never ack, else ack in that REQ cycle (1..TO).
  task automatic do_load(input int mode, input int addr,
                         input logic [31:0] d,
                         input int ack_at,
                         input bit poke);
    logic [31:0] e;
    bool_end: begin end
    e = ref_ext(mode, addr, d);
    @(posedge clk);
    ld_start   = 1'b1;
    ld_mode    = 3'(mode);
    ld_addr_lo = 2'(addr);
    mem_ack    = 1'b0;
    @(posedge clk);
    ld_start = 1'b0;
    #1;
    if (!ref_legal(mode, addr)) begin
      exp_err   = 1'b1;
      exp_valid = 1'b0;
      chk("illegal_req", 32'(mem_req), 32'd0);
      chk_state("illegal");
      return;
    end
    exp_err   = 1'b0;
    exp_valid = 1'b0;
    chk("req_up", 32'(mem_req), 32'd1);
    chk("busy_up", 32'(dr_busy), 32'd1);
    for (int i = 1; i <= TO; i++) begin
      mem_ack   = (i == ack_at);
      mem_rdata = (i == ack_at) ? d : 32'($urandom);
      if (poke && i == 1) begin
        ld_start   = 1'b1;
        ld_mode    = 3'($urandom_range(0, 4));
        ld_addr_lo = 2'($urandom_range(0, 3));
      end
      #1;
      if (i == ack_at) begin
`ifdef DR_BYPASS_EN
        chk("ack_cycle_rdata", dr_rdata, e);
`else
        chk("ack_cycle_rdata", dr_rdata, exp_reg);
`endif
      end
      @(posedge clk);
      mem_ack  = 1'b0;
      ld_start = 1'b0;
      if (i == ack_at || i == TO) break;
      if (i == TO - 1) begin
        #1;
        chk("req_hold", 32'(mem_req), 32'd1);
      end
    end
    #1;
    if (ack_at != 0) begin
      exp_reg   = e;
      exp_valid = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    chk("req_drop", 32'(mem_req), 32'd0);
    chk("busy_drop", 32'(dr_busy), 32'd0);
    chk_state("done");
  endtask

  initial begin
    rst_n      = 1'b0;
    ld_start   = 1'b0;
    ld_mode    = 3'd0;
    ld_addr_lo = 2'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    dr_out     = 1'b1;
    exp_reg    = 32'd0;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(dr_busy), 32'd0);
    chk_state("rst");
    @(posedge clk);
    rst_n = 1'b1;

    do_load(1, 2, 32'h1280_3456, 3, 1'b0);
    chk("bs_const", dr_rdata, 32'hFFFF_FF80);
    dr_out = 1'b0;
    #1;
    chk("out_off", dr_rdata, 32'd0);
    dr_out = 1'b1;

    do_load(4, 2, 32'h8001_7FFF, 2, 1'b0);
    chk("hu_const", dr_rdata, 32'h0000_8001);
    do_load(3, 0, 32'h8001_7FFF, 1, 1'b0);
    chk("hs_const", dr_rdata, 32'h0000_7FFF);

    do_load(3, 1, 32'hAAAA_AAAA, 1, 1'b0);
    chk("mis_keep", dr_rdata, 32'h0000_7FFF);
    do_load(2, 3, 32'hC3C3_C3C3, 2, 1'b0);
    chk("err_clear", 32'(dr_err), 32'd0);

    do_load(0, 0, 32'h5555_AAAA, 0, 1'b0);
    chk("to_err", 32'(dr_err), 32'd1);
    chk("to_keep", dr_rdata, 32'h0000_00C3);
    do_load(0, 0, 32'h1357_9BDF, TO, 1'b1);
    chk("ack15_err", 32'(dr_err), 32'd0);
    chk("ack15_data", dr_rdata, 32'h1357_9BDF);

    do_load(0, 0, 32'hDEAD_BEEF, 1, 1'b0);
    do_load(7, 0, 32'h0, 1, 1'b0);

    @(posedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk);
    mem_ack = 1'b0;
    #1;
    chk("idle_ack_data", dr_rdata, exp_reg);
    chk("idle_ack_req", 32'(mem_req), 32'd0);

    @(posedge clk);
    ld_start = 1'b1;
    ld_mode  = 3'd0;
    ld_addr_lo = 2'd0;
    @(posedge clk);
    ld_start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_reg   = 32'd0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk_state("mid_rst");
    @(posedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      do_load(int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)),
              32'($urandom),
              int'($urandom_range(0, TO)),
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/dr_load_unit.md
Name: dr_load_unit

Overview:
- Parametrised successor to the single data register of the multi-cycle datapath.
- Issues one memory read per load over a req/ack handshake and bounds the wait with a timeout.
- Aligns and sign/zero-extends the selected byte, halfword or full word, then holds the result for the write-back cycle.
- Sits between the memory bus and the register-file write port; the control FSM drives it.

Parameters:
- DATA_W, 32, data width in bits; multiple of 16, minimum 32.
- TIMEOUT, 15, maximum wait cycles for mem_ack before abort; must be ≥1.
- TO_W, 4, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the datapath registers.
- rst_n  in  1  asynchronous active-low reset.
- ld_start  in  1  one-cycle pulse: begin a load.
- ld_mode  in  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; 101–111 illegal.
- ld_addr_lo  in  $clog2(DATA_W/8)  byte offset within the bus word.
- mem_req  out  1  read request to memory.
- mem_ack  in  1  memory data valid on mem_rdata.
- mem_rdata  in  DATA_W  memory read data, little-endian lanes.
- dr_out  in  1  output enable.
- dr_rdata  out  DATA_W  held register value when dr_out=1, else 0.
- dr_valid  out  1  register holds a completed load.
- dr_busy  out  1  load in progress.
- dr_err  out  1  sticky error: misaligned, illegal mode or timeout.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, data register 0, counter 0, mem_req 0, dr_valid 0, dr_busy 0, dr_err 0. dr_rdata reads 0.
- States: IDLE, REQ.
- IDLE, ld_start=1 with a legal access:
  - Latch ld_mode and ld_addr_lo.
  - Clear dr_valid and dr_err; clear the counter.
  - Next state REQ.
- Legal access: word needs addr_lo==0; half needs addr_lo[0]==0; byte has no constraint; mode must be 000–100.
- IDLE, ld_start=1 with an illegal access:
  - Stay IDLE; set dr_err and clear dr_valid.
  - Data register unchanged; mem_req never asserted.
- REQ:
  - mem_req=1 and dr_busy=1, both registered outputs of the state.
  - On mem_ack=1: capture the extended data, set dr_valid, go to IDLE. mem_req drops at the same edge.
  - Without ack: the counter increments. On the edge where the counter reaches TIMEOUT, set dr_err, leave the data register unchanged, go to IDLE.
- mem_ack and timeout on the same edge: ack wins; no error.
- Extension:
  - Byte = mem_rdata[8*addr_lo +: 8].
  - Half = mem_rdata[8*addr_lo +: 16].
  - Signed modes replicate the MSB to DATA_W; unsigned modes zero-fill; word is passed unchanged.
- ld_start while in REQ: ignored, with no effect on the latched mode or address.
- mem_ack while in IDLE: ignored.
- dr_valid stays set until the next accepted ld_start or until reset.
- dr_err stays set until the next accepted ld_start or until reset.
- dr_rdata is combinational: dr_out ? register : 0. Independent of state.
- Reset asserted in REQ: immediate return to IDLE; mem_req deasserts asynchronously.
- Load latency: mem_req is high from the first falling edge after ld_start until the falling edge that samples mem_ack. Minimum 2 falling edges from ld_start to dr_valid.

Optional Feature:
- Macro: DR_BYPASS_EN.
- With the macro defined: while in REQ with mem_ack=1 and dr_out=1, dr_rdata presents the extended mem_rdata combinationally, giving same-cycle forwarding to write-back. All other cycles are unchanged.
- Without the macro: dr_rdata shows only the registered value, so new data is visible after the capturing edge.

Test Plan:
- Reset mid-load: ld_start with word mode, then rst_n=0 during REQ → mem_req=0 immediately; dr_valid=0, dr_err=0, dr_rdata=0 with dr_out=1.
- Byte signed, addr_lo=2, mem_rdata=0x12_80_34_56, ack after 3 cycles → register 0xFFFFFF80, dr_valid=1, dr_err=0; with dr_out=0, dr_rdata=0.
- Half unsigned, addr_lo=2, mem_rdata=0x8001_7FFF → 0x00008001. Half signed at addr_lo=0 on the same data → 0x00007FFF.
- Misaligned half, addr_lo=1 → dr_err=1, mem_req never 1, register keeps its prior value. The next legal ld_start clears dr_err.
- Timeout: word load, mem_ack held 0 → dr_err=1 after exactly 15 REQ cycles; register unchanged. Second case with ack on cycle 15 → data captured, dr_err=0.
- DR_BYPASS_EN: word load, mem_rdata=0xDEADBEEF, dr_out=1 → dr_rdata=0xDEADBEEF during the ack cycle. Without the macro, dr_rdata shows the old value until the edge after ack.
